output_backprop: RTL and testbench

OUTPUT_BACKPROP -- requirements
Module: output_backprop

---
 rtl/output_backprop.sv | 150 +++++++++++++++
 tb/tb_output_backprop.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_backprop.sv
// Output-layer backprop weight updater: two error terms, then eight weight/bias updates
// through one shared multiplier. Define OUTPUT_BACKPROP_WEIGHT_SAT_EN for saturating updates.
module output_backprop #(
   parameter int DWIDTH = 32,
   parameter int frac   = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DWIDTH-1:0] A,
   input  logic signed [DWIDTH-1:0] B,
   input  logic signed [DWIDTH-1:0] C,
   input  logic signed [DWIDTH-1:0] out1,
   input  logic signed [DWIDTH-1:0] out2,
   input  logic signed [DWIDTH-1:0] target1,
   input  logic signed [DWIDTH-1:0] target2,
   input  logic signed [DWIDTH-1:0] lr,
   input  logic                     load,
   input  logic [2:0]               load_addr,
   input  logic signed [DWIDTH-1:0] load_data,
   output logic signed [DWIDTH-1:0] wa1,
   output logic signed [DWIDTH-1:0] wa2,
   output logic signed [DWIDTH-1:0] wb1,
   output logic signed [DWIDTH-1:0] wb2,
   output logic signed [DWIDTH-1:0] wc1,
   output logic signed [DWIDTH-1:0] wc2,
   output logic signed [DWIDTH-1:0] bias1,
   output logic signed [DWIDTH-1:0] bias2,
   output logic                     busy,
   output logic                     done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ERR1 = 2'd1;
   localparam logic [1:0] ERR2 = 2'd2;
   localparam logic [1:0] UPD  = 2'd3;

   logic [1:0] state;
   logic [2:0] idx;

   logic signed [DWIDTH-1:0] a_q, b_q, c_q, o1_q, o2_q, t1_q, t2_q, lr_q;
   logic signed [DWIDTH-1:0] d1, d2;
   logic signed [DWIDTH-1:0] w [8];

   logic signed [DWIDTH-1:0]   mul_a, mul_b, mul_res, d_sel, delta, acc;
   logic signed [2*DWIDTH-1:0] prod;

   function automatic logic signed [DWIDTH-1:0] acc_add(input logic signed [DWIDTH-1:0] x,
                                                         input logic signed [DWIDTH-1:0] y);
      logic signed [DWIDTH-1:0] s;
      s = x + y;
`ifdef OUTPUT_BACKPROP_WEIGHT_SAT_EN
      if ((x[DWIDTH-1] == y[DWIDTH-1]) && (s[DWIDTH-1] != x[DWIDTH-1])) begin
         s = x[DWIDTH-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
      end
`endif
      return s;
   endfunction

   // Even idx updates the *1 register with d1, odd idx the *2 register with d2; idx matches
   // the load_addr register map, so one index drives both.
   always_comb begin
      d_sel = idx[0] ? d2 : d1;
      mul_a = lr_q;
      mul_b = t1_q - o1_q;
      case (state)
         ERR2: mul_b = t2_q - o2_q;
         UPD: begin
            mul_a = d_sel;
            case (idx[2:1])
               2'd0:    mul_b = a_q;
               2'd1:    mul_b = b_q;
               default: mul_b = c_q;
            endcase
         end
         default: ;
      endcase
   end

   assign prod    = {{DWIDTH{mul_a[DWIDTH-1]}}, mul_a} * {{DWIDTH{mul_b[DWIDTH-1]}}, mul_b};
   assign mul_res = DWIDTH'(prod >>> frac);
   assign delta   = (idx[2:1] == 2'b11) ? d_sel : mul_res;
   assign acc     = acc_add(w[idx], delta);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= 3'd0;
         done  <= 1'b0;
         d1    <= '0;
         d2    <= '0;
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         o1_q  <= '0;
         o2_q  <= '0;
         t1_q  <= '0;
         t2_q  <= '0;
         lr_q  <= '0;
         for (int i = 0; i < 8; i++) w[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  w[load_addr] <= load_data;
               end else if (start) begin
                  a_q   <= A;
                  b_q   <= B;
                  c_q   <= C;
                  o1_q  <= out1;
                  o2_q  <= out2;
                  t1_q  <= target1;
                  t2_q  <= target2;
                  lr_q  <= lr;
                  state <= ERR1;
               end
            end
            ERR1: begin
               d1    <= mul_res;
               state <= ERR2;
            end
            ERR2: begin
               d2    <= mul_res;
               idx   <= 3'd0;
               state <= UPD;
            end
            default: begin
               w[idx] <= acc;
               idx    <= idx + 3'd1;
               if (idx == 3'd7) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign wa1   = w[0];
   assign wa2   = w[1];
   assign wb1   = w[2];
   assign wb2   = w[3];
   assign wc1   = w[4];
   assign wc2   = w[5];
   assign bias1 = w[6];
   assign bias2 = w[7];

endmodule

// File: tb/tb_output_backprop.sv
// Scoreboard bench for output_backprop: passes push expected weights and done cycle,
// a monitor pops and compares on every done pulse.
module tb_output_backprop;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        load = 1'b0;
   logic [2:0]  load_addr = 3'd0;
   logic [31:0] load_data = '0;
   logic [31:0] a_in = '0, b_in = '0, c_in = '0, out1 = '0, out2 = '0;
   logic [31:0] target1 = '0, target2 = '0, lr = '0;
   logic [31:0] wa1, wa2, wb1, wb2, wc1, wc2, bias1, bias2;
   logic        busy, done;

   logic [7:0][31:0] wv;
   assign wv = {bias2, bias1, wc2, wc1, wb2, wb1, wa2, wa1};

   typedef struct packed {
      logic [7:0][31:0] w;
      logic [31:0]      cyc;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] cyc = '0;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_done = 0;
   string       names [8] = '{"wa1", "wa2", "wb1", "wb2", "wc1", "wc2", "bias1", "bias2"};

   output_backprop dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .A        (a_in),
      .B        (b_in),
      .C        (c_in),
      .out1     (out1),
      .out2     (out2),
      .target1  (target1),
      .target2  (target2),
      .lr       (lr),
      .load     (load),
      .load_addr(load_addr),
      .load_data(load_data),
      .wa1      (wa1),
      .wa2      (wa2),
      .wb1      (wb1),
      .wb2      (wb2),
      .wc1      (wc1),
      .wc2      (wc2),
      .bias1    (bias1),
      .bias2    (bias2),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected pass.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
               check("unexpected done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("done cycle", cyc, e.cyc);
               for (int i = 0; i < 8; i++) check(names[i], wv[i], e.w[i]);
            end
         end
      end
   end

   function automatic exp_t mk(input logic [31:0] w0, w2, w6);
      exp_t e;
      e.w    = '0;
      e.w[0] = w0;
      e.w[2] = w2;
      e.w[6] = w6;
      e.cyc  = cyc + 32'd11;
      return e;
   endfunction

   task automatic set_ops();
      a_in = 32'h0100_0000; b_in = 32'h0080_0000; c_in = 32'h0;
      out1 = 32'h0080_0000; target1 = 32'h0100_0000;
      out2 = 32'h0;         target2 = 32'h0;
      lr   = 32'h0080_0000;
   endtask

   task automatic scramble_ops();
      a_in = 32'h7FFF_FFFF; b_in = 32'h8000_0000; c_in = 32'h1234_5678;
      out1 = 32'hDEAD_BEEF; target1 = 32'h0; out2 = 32'h0F00_0000;
      target2 = 32'hF000_0000; lr = 32'h0100_0000;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 60) begin
         @(negedge clk);
         t++;
      end
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] addr, input logic [31:0] data);
      @(negedge clk);
      load = 1'b1; load_addr = addr; load_data = data;
      @(negedge clk);
      load = 1'b0;
      check("busy during load", 32'(busy), 32'd0);
      check("done during load", 32'(done), 32'd0);
   endtask

   task automatic run_pass(input exp_t e_in);
      exp_t e;
      @(negedge clk);
      set_ops();
      start = 1'b1;
      e = e_in;
      e.cyc = cyc + 32'd11;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      scramble_ops();
      wait_drain();
   endtask

   initial begin
      exp_t e;
      int   d0;

      // Asynchronous reset with no clock edge yet
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) check({"rst ", names[i]}, wv[i], 32'h0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Load every register
      for (int i = 0; i < 8; i++) do_load(3'(i), 32'h0100_0000);
      for (int i = 0; i < 8; i++) check({"load ", names[i]}, wv[i], 32'h0100_0000);

      // Basic pass from zero weights
      do_reset();
      run_pass(mk(32'h0040_0000, 32'h0020_0000, 32'h0040_0000));

      // Overflow on wa1
      do_reset();
      do_load(3'd0, 32'h7FFF_FF00);
`ifdef OUTPUT_BACKPROP_WEIGHT_SAT_EN
      run_pass(mk(32'h7FFF_FFFF, 32'h0020_0000, 32'h0040_0000));
`else
      run_pass(mk(32'h803F_FF00, 32'h0020_0000, 32'h0040_0000));
`endif

      // Start held across two passes; loads while busy are ignored
      do_reset();
      @(negedge clk);
      set_ops();
      d0 = n_done;
      e = mk(32'h0040_0000, 32'h0020_0000, 32'h0040_0000);
      sb.push_back(e);
      e = mk(32'h0080_0000, 32'h0040_0000, 32'h0080_0000);
      e.cyc = cyc + 32'd22;
      sb.push_back(e);
      for (int i = 0; i < 22; i++) begin
         start = 1'b1;
         load = (i == 3 || i == 15);
         load_addr = 3'd0;
         load_data = 32'h1234_5678;
         @(negedge clk);
      end
      start = 1'b0;
      load = 1'b0;
      wait_drain();
      repeat (15) @(negedge clk);
      check("held start done count", 32'(n_done - d0), 32'd2);

      // Reset in the middle of a pass (at update idx 3)
      do_reset();
      @(negedge clk);
      set_ops();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("mid wa1", wa1, 32'h0040_0000);
      check("mid wb1", wb1, 32'h0020_0000);
      check("mid busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) check({"abort ", names[i]}, wv[i], 32'h0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_pass(mk(32'h0040_0000, 32'h0020_0000, 32'h0040_0000));

      // Load beats a simultaneous start
      do_reset();
      @(negedge clk);
      set_ops();
      start = 1'b1; load = 1'b1; load_addr = 3'd6; load_data = 32'h0010_0000;
      @(negedge clk);
      start = 1'b0; load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("load+start busy", 32'(busy), 32'd0);
         @(negedge clk);
      end
      check("load+start bias1", bias1, 32'h0010_0000);
      check("load+start wa1", wa1, 32'h0);
      repeat (12) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
